// File: rtl/car_layer_mixer_if.sv
// car_layer_mixer_if
//   Bundle of the pixel/frame signals between the sprite producers and the
//   car layer mixer.
//   master : drives frame_start, road_color, player_color, ai_colors and
//            observes the mixer outputs.
//   slave  : the mixer itself; drives rgb_out, crash_pulse, freeze, grace,
//            crash_count and the debug state.
//   No valid/ready handshake exists on this bus: colors are sampled on every
//   clock edge, and frame_start is a one-cycle qualifier that is acted on at
//   the edge where it is high.
interface car_layer_mixer_if #(
  parameter int NUM_AI = 2
);
  logic                    frame_start;
  logic [7:0]              road_color;
  logic [7:0]              player_color;
  logic [0:NUM_AI-1][7:0]  ai_colors;
  logic [7:0]              rgb_out;
  logic                    crash_pulse;
  logic                    freeze;
  logic                    grace;
  logic [7:0]              crash_count;
  logic [1:0]              state;

  modport master (
    output frame_start, road_color, player_color, ai_colors,
    input  rgb_out, crash_pulse, freeze, grace, crash_count, state
  );

  modport slave (
    input  frame_start, road_color, player_color, ai_colors,
    output rgb_out, crash_pulse, freeze, grace, crash_count, state
  );
endinterface

// File: rtl/car_layer_mixer.sv
// car_layer_mixer
//   Merges road, player and NUM_AI AI car colors by priority into a
//   registered VGA byte, detects player/AI pixel overlap and runs the
//   per-frame RUN -> CRASH -> GRACE state machine.
// Ports:
//   clk     : pixel clock
//   resetN  : asynchronous active-low reset
//   bus     : car_layer_mixer_if.slave (colors, frame_start, mixer outputs,
//             debug FSM state)
// Optional build macro:
//   CAR_LAYER_FLASH_EN : blink the player every 8 frames while in GRACE.
module car_layer_mixer #(
  parameter int         NUM_AI       = 2,
  parameter logic [7:0] MASK_VALUE   = 8'h62,
  parameter int         CRASH_FRAMES = 60,
  parameter int         GRACE_FRAMES = 90
) (
  input logic             clk,
  input logic             resetN,
  car_layer_mixer_if.slave bus
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_CRASH = 2'd1;
  localparam logic [1:0] ST_GRACE = 2'd2;

  localparam logic [7:0] CRASH_LOAD = 8'(CRASH_FRAMES - 1);
  localparam logic [7:0] GRACE_LOAD = 8'(GRACE_FRAMES - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       hit_q, hit_d;
  logic       pulse_q, pulse_d;
  logic [7:0] count_q, count_d;
  logic [7:0] rgb_q, rgb_d;
  logic       player_on;
  logic       any_ai_on;
  logic       overlap;
  logic       hide_player;

`ifdef CAR_LAYER_FLASH_EN
  logic [3:0] flash_q, flash_d;

  always_comb begin
    flash_d = flash_q;
    if (state_q != ST_GRACE && state_d == ST_GRACE) begin
      flash_d = 4'd0;
    end else if (state_q == ST_GRACE && bus.frame_start) begin
      flash_d = flash_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) flash_q <= 4'd0;
    else         flash_q <= flash_d;
  end

  assign hide_player = (state_q == ST_GRACE) && flash_q[3];
`else
  assign hide_player = 1'b0;
`endif

  // Collision detection always looks at the real player pixel; flashing
  // only affects what is drawn.
  assign player_on = (bus.player_color != MASK_VALUE);

  always_comb begin
    any_ai_on = 1'b0;
    for (int i = 0; i < NUM_AI; i++) begin
      if (bus.ai_colors[i] != MASK_VALUE) any_ai_on = 1'b1;
    end
  end

  assign overlap = player_on && any_ai_on;

  // Walk from lowest to highest priority so the last hit wins.
  always_comb begin
    rgb_d = bus.road_color;
    for (int i = NUM_AI - 1; i >= 0; i--) begin
      if (bus.ai_colors[i] != MASK_VALUE) rgb_d = bus.ai_colors[i];
    end
    if (player_on && !hide_player) rgb_d = bus.player_color;
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    count_d     = count_q;
    pulse_d     = 1'b0;
    // The RUN decision uses hit_q from before this cycle's clear/set.
    if (bus.frame_start) begin
      case (state_q)
        ST_RUN: begin
          if (hit_q) begin
            state_d     = ST_CRASH;
            frame_cnt_d = CRASH_LOAD;
            pulse_d     = 1'b1;
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
          end
        end
        ST_CRASH: begin
          if (frame_cnt_q == 8'd0) begin
            state_d     = ST_GRACE;
            frame_cnt_d = GRACE_LOAD;
          end else begin
            frame_cnt_d = frame_cnt_q - 8'd1;
          end
        end
        ST_GRACE: begin
          if (frame_cnt_q == 8'd0) state_d     = ST_RUN;
          else                     frame_cnt_d = frame_cnt_q - 8'd1;
        end
        default: begin
          state_d     = ST_RUN;
          frame_cnt_d = 8'd0;
        end
      endcase
    end
  end

  // Clear on frame_start first, then set: an overlap coincident with
  // frame_start is credited to the new frame.
  always_comb begin
    hit_d = hit_q;
    if (bus.frame_start) hit_d = 1'b0;
    if (overlap && state_q == ST_RUN) hit_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_RUN;
      frame_cnt_q <= 8'd0;
      hit_q       <= 1'b0;
      pulse_q     <= 1'b0;
      count_q     <= 8'd0;
      rgb_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      hit_q       <= hit_d;
      pulse_q     <= pulse_d;
      count_q     <= count_d;
      rgb_q       <= rgb_d;
    end
  end

  assign bus.rgb_out     = rgb_q;
  assign bus.crash_pulse = pulse_q;
  assign bus.freeze      = (state_q == ST_CRASH);
  assign bus.grace       = (state_q == ST_GRACE);
  assign bus.crash_count = count_q;
  assign bus.state       = state_q;

endmodule
